// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1 UART transmitter, LSB first, idle-high line.
// Producers push bytes through tx_valid/tx_ready into a circular FIFO; the FSM serialises them onto RsTx.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_AW      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_valid,
  input  logic [7:0]       tx_byte,
  output logic             tx_ready,
  output logic             RsTx,
  output logic             o_TX_Active,
  output logic             o_TX_Done,
  output logic [FIFO_AW:0] fifo_count
);
  localparam int                 DEPTH     = 1 << FIFO_AW;
  localparam logic [15:0]        BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0]   FULL      = DEPTH[FIFO_AW:0];
  localparam logic [FIFO_AW:0]   CNT_ONE   = 1;
  localparam logic [FIFO_AW-1:0] PTR_ONE   = 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t             state, state_next;
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count_next;
  logic               push, pop;
  logic [7:0]         shift;
  logic [15:0]        clk_cnt;
  logic [2:0]         bit_idx;
  logic               bit_end;
  logic               line_d, active_d, done_d;

  // tx_ready is registered, so a full FIFO refuses a push even on a pop edge
  assign push    = tx_valid && tx_ready;
  assign pop     = (state == IDLE) && (fifo_count != '0);
  assign bit_end = (clk_cnt == BIT_LAST);

  always_comb begin
    count_next = fifo_count;
    if (push && !pop)
      count_next = fifo_count + CNT_ONE;
    else if (pop && !push)
      count_next = fifo_count - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (push && !rst)
      mem[wr_ptr] <= tx_byte;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      tx_ready   <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      fifo_count <= count_next;
      tx_ready   <= (count_next < FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:    state_next = pop ? START : IDLE;
      START:   state_next = bit_end ? DATA : START;
      DATA:    state_next = (bit_end && bit_idx == 3'd7) ? STOP : DATA;
      STOP:    state_next = bit_end ? DONE : STOP;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // bit-period counter restarts at every bit boundary, so no drift accumulates
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else if (pop) begin
      shift   <= mem[rd_ptr];
      clk_cnt <= '0;
      bit_idx <= '0;
    end else if (state == START || state == DATA || state == STOP) begin
      if (bit_end) begin
        clk_cnt <= '0;
        if (state == DATA) bit_idx <= bit_idx + 3'd1;
      end else begin
        clk_cnt <= clk_cnt + 16'd1;
      end
    end else begin
      clk_cnt <= '0;
    end
  end

  always_comb begin
    line_d   = 1'b1;
    active_d = 1'b0;
    done_d   = 1'b0;
    case (state)
      START: begin line_d = 1'b0;           active_d = 1'b1; end
      DATA:  begin line_d = shift[bit_idx]; active_d = 1'b1; end
      STOP:  active_d = 1'b1;
      DONE:  done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      RsTx        <= 1'b1;
      o_TX_Active <= 1'b0;
      o_TX_Done   <= 1'b0;
    end else begin
      RsTx        <= line_d;
      o_TX_Active <= active_d;
      o_TX_Done   <= done_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a line decoder scoreboards every frame against queued bytes;
// directed FIFO/timing scenarios run at 8 clocks/bit and a random stream at the default rate.
module tb_uart_tx_fifo;
  localparam int C0 = 8;
  localparam int C1 = 868;
  localparam int NSTREAM = 8;

  logic clk = 1'b0;
  logic rst0 = 1'b1, rst1 = 1'b1;
  logic v0 = 1'b0, v1 = 1'b0;
  logic [7:0] b0 = '0, b1 = '0;
  logic rdy0, rs0, act0, done0, rdy1, rs1, act1, done1;
  logic [4:0] cnt0, cnt1;

  int tests = 0, fails = 0;
  int cyc = 0;
  int abort_cnt = 0;
  logic [7:0] q0[$], q1[$];
  int starts0[$], dones0[$];
  int frames0 = 0, frames1 = 0, dones1_n = 0;
  logic stream_done = 1'b0;

  uart_tx_fifo #(.CLKS_PER_BIT(C0), .FIFO_AW(4)) dut0 (
    .clk(clk), .rst(rst0), .tx_valid(v0), .tx_byte(b0), .tx_ready(rdy0),
    .RsTx(rs0), .o_TX_Active(act0), .o_TX_Done(done0), .fifo_count(cnt0));

  uart_tx_fifo dut1 (
    .clk(clk), .rst(rst1), .tx_valid(v1), .tx_byte(b1), .tx_ready(rdy1),
    .RsTx(rs1), .o_TX_Active(act1), .o_TX_Done(done1), .fifo_count(cnt1));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst0) abort_cnt <= abort_cnt + 1;
  end

  always @(negedge clk) begin
    if (done0) dones0.push_back(cyc);
    if (done1) dones1_n++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic line_of(input int id);
    return (id == 0) ? rs0 : rs1;
  endfunction

  // Called at the first low sample of a start bit; samples each bit near its centre.
  task automatic decode(input int id, input int c, output logic [7:0] data, output logic ok);
    data = '0;
    ok = 1'b1;
    repeat (c / 2) @(negedge clk);
    if (line_of(id) !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (c) @(negedge clk);
      data[i] = line_of(id);
    end
    repeat (c) @(negedge clk);
    if (line_of(id) !== 1'b1) ok = 1'b0;
  endtask

  initial begin : mon0
    logic [7:0] d;
    logic ok;
    int ab;
    forever begin
      @(negedge clk);
      if (!rst0 && rs0 === 1'b0) begin
        ab = abort_cnt;
        starts0.push_back(cyc);
        frames0++;
        decode(0, C0, d, ok);
        if (ab == abort_cnt) begin
          check("frame0_format", ok, 1);
          if (q0.size() == 0) begin
            tests++; fails++;
            $display("FAIL frame0_unexpected: got 0x%0h expected no frame", d);
          end else begin
            check("frame0_byte", d, q0.pop_front());
          end
        end
      end
    end
  end

  initial begin : mon1
    logic [7:0] d;
    logic ok;
    forever begin
      @(negedge clk);
      if (!rst1 && rs1 === 1'b0) begin
        frames1++;
        decode(1, C1, d, ok);
        check("frame1_format", ok, 1);
        if (q1.size() == 0) begin
          tests++; fails++;
          $display("FAIL frame1_unexpected: got 0x%0h expected no frame", d);
        end else begin
          check("frame1_byte", d, q1.pop_front());
        end
      end
    end
  end

  // Line transitions must be at least one bit period apart (reset aborts excused).
  initial begin : glitch
    logic p0, p1;
    int t0, t1, ab0;
    p0 = 1'b1; p1 = 1'b1; t0 = -1000000; t1 = -1000000; ab0 = 0;
    forever begin
      @(negedge clk);
      if (rs0 !== p0) begin
        if (ab0 == abort_cnt) check("glitch0_spacing", (cyc - t0) >= C0, 1);
        p0 = rs0; t0 = cyc; ab0 = abort_cnt;
      end
      if (rs1 !== p1) begin
        check("glitch1_spacing", (cyc - t1) >= C1, 1);
        p1 = rs1; t1 = cyc;
      end
    end
  end

  initial begin : stream
    logic [7:0] d;
    wait (rst1 == 1'b0);
    for (int i = 0; i < NSTREAM; i++) begin
      tick($urandom_range(0, 20));
      d = 8'($urandom);
      check("t6_ready", rdy1, 1);
      v1 = 1'b1; b1 = d; q1.push_back(d);
      tick();
      v1 = 1'b0;
    end
    stream_done = 1'b1;
  end

  task automatic drain0(input string name, input int budget);
    int n;
    n = 0;
    while ((q0.size() != 0 || act0 !== 1'b0) && n < budget) begin
      tick();
      n++;
    end
    check(name, n < budget, 1);
    tick(4);
  endtask

  initial begin : main
    int n, k, s, dcount, fcount;
    logic [7:0] t2 [3];
    t2[0] = 8'h00; t2[1] = 8'hFF; t2[2] = 8'h55;

    tick(3);
    check("rst_line", rs0, 1);
    check("rst_active", act0, 0);
    check("rst_done", done0, 0);
    check("rst_ready", rdy0, 1);
    check("rst_count", cnt0, 0);
    rst0 = 1'b0;
    rst1 = 1'b0;
    tick(2);

    // single byte: exact start latency, fifo_count 1 then 0, done 10 bit periods after start
    v0 = 1'b1; b0 = 8'hA5; q0.push_back(8'hA5);
    tick();
    v0 = 1'b0;
    check("t1_count_after_push", cnt0, 1);
    check("t1_line_idle_n", rs0, 1);
    tick();
    check("t1_count_after_pop", cnt0, 0);
    check("t1_line_idle_n1", rs0, 1);
    tick();
    check("t1_start_bit", rs0, 0);
    check("t1_active", act0, 1);
    s = cyc;
    drain0("t1_drain", 200);
    check("t1_done_pulses", dones0.size(), 1);
    if (dones0.size() >= 1) check("t1_done_delay", dones0[0] - s, 10 * C0);

    // three back-to-back frames: 82-cycle start spacing, 2-cycle active gaps
    k = starts0.size();
    for (int i = 0; i < 3; i++) begin
      v0 = 1'b1; b0 = t2[i]; q0.push_back(t2[i]);
      tick();
    end
    v0 = 1'b0;
    n = 0;
    while (act0 !== 1'b1 && n < 20) begin tick(); n++; end
    for (int g = 0; g < 2; g++) begin
      n = 0;
      while (act0 !== 1'b0 && n < 200) begin tick(); n++; end
      n = 0;
      while (act0 === 1'b0 && n < 20) begin n++; tick(); end
      check("t2_active_gap", n, 2);
    end
    drain0("t2_drain", 400);
    check("t2_frames", starts0.size() - k, 3);
    if (starts0.size() - k == 3) begin
      check("t2_spacing_a", starts0[k + 1] - starts0[k], 10 * C0 + 2);
      check("t2_spacing_b", starts0[k + 2] - starts0[k + 1], 10 * C0 + 2);
    end

    // overfill: 16 queued plus one in the shifter; full FIFO refuses a push on a pop edge
    for (int i = 0; i < 20; i++) begin
      v0 = 1'b1; b0 = 8'(16 + i);
      if (i <= 16) q0.push_back(8'(16 + i));
      tick();
    end
    v0 = 1'b0;
    check("t3_count_full", cnt0, 16);
    check("t3_ready_full", rdy0, 0);
    tick(63);
    check("t5_count_before_pop", cnt0, 16);
    v0 = 1'b1; b0 = 8'h99;
    tick();
    v0 = 1'b0;
    check("t5_full_push_pop_count", cnt0, 15);
    check("t5_ready_after_pop", rdy0, 1);
    drain0("t3_drain", 17 * 82 + 100);

    // push and pop on the same edge with five queued
    for (int i = 0; i < 6; i++) begin
      v0 = 1'b1; b0 = 8'(8'h60 + i); q0.push_back(8'(8'h60 + i));
      tick();
    end
    v0 = 1'b0;
    tick(77);
    check("t5_count_before", cnt0, 5);
    v0 = 1'b1; b0 = 8'h66; q0.push_back(8'h66);
    tick();
    v0 = 1'b0;
    check("t5_push_pop_count", cnt0, 5);
    drain0("t5_drain", 7 * 82 + 100);

    // reset mid-DATA of 0xC3 with three queued
    for (int i = 0; i < 4; i++) begin
      v0 = 1'b1;
      b0 = (i == 0) ? 8'hC3 : 8'(8'h11 * i);
      tick();
    end
    v0 = 1'b0;
    check("t4_count_queued", cnt0, 3);
    tick(36);
    rst0 = 1'b1;
    tick();
    q0.delete();
    check("t4_line_high", rs0, 1);
    check("t4_count_zero", cnt0, 0);
    check("t4_ready", rdy0, 1);
    check("t4_active", act0, 0);
    rst0 = 1'b0;
    dcount = dones0.size();
    fcount = frames0;
    tick(200);
    check("t4_no_done", dones0.size(), dcount);
    check("t4_no_frames", frames0, fcount);
    check("t4_line_idle", rs0, 1);

    // wait for the default-rate random stream to finish
    n = 0;
    while ((!stream_done || q1.size() != 0 || act1 !== 1'b0) && n < 90000) begin
      tick();
      n++;
    end
    check("t6_drain", n < 90000, 1);
    tick(4);
    check("t6_frames", frames1, NSTREAM);
    check("t6_done_pulses", dones1_n, NSTREAM);
    check("t6_count_empty", cnt1, 0);
    check("t0_queue_empty", q0.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
